// File: rtl/multiword_add_sequencer_pkg.sv
// multiword_add_sequencer_pkg: shared slice width, FSM states and slice-count helper
package multiword_add_sequencer_pkg;
  localparam int SLICE_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction
endpackage

// File: rtl/conditional_sum_adder16_with_cin.sv
// conditional_sum_adder16_with_cin: 16-bit adder, upper byte precomputed for both
// carry values and selected by the lower byte's carry out
module conditional_sum_adder16_with_cin
  import multiword_add_sequencer_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);
  localparam int H = SLICE_W / 2;
  logic [H:0] lo, hi0, hi1;
  assign lo  = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + (H+1)'(cin);
  assign hi0 = {1'b0, a[SLICE_W-1:H]} + {1'b0, b[SLICE_W-1:H]};
  assign hi1 = {1'b0, a[SLICE_W-1:H]} + {1'b0, b[SLICE_W-1:H]} + (H+1)'(1);
  assign sum  = {lo[H] ? hi1[H-1:0] : hi0[H-1:0], lo[H-1:0]};
  assign cout = lo[H] ? hi1[H] : hi0[H];
endmodule

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: WIDTH-bit add sequenced over one 16-bit slice adder, LSB slice first.
// Define MWADD_SUB_EN to add the op_sub port (a - b - cin, cout=1 means no borrow).
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef MWADD_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NSLICE = nslice(WIDTH);
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, cout_q, cout_d;
  logic sub, last, s_cout;
  logic [SLICE_W-1:0] s_sum;
`ifdef MWADD_SUB_EN
  assign sub = op_sub;
`else
  assign sub = 1'b0;
`endif
  assign last = idx_q == IW'(NSLICE - 1);
  conditional_sum_adder16_with_cin u_slice (
    .a   (a_q[idx_q*SLICE_W +: SLICE_W]),
    .b   (b_q[idx_q*SLICE_W +: SLICE_W]),
    .cin (carry_q),
    .sum (s_sum),
    .cout(s_cout)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = sub ? ~b : b;
        carry_d = cin ^ sub;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = s_sum;
        carry_d = s_cout;
        idx_d   = last ? '0 : idx_q + IW'(1);
        cout_d  = last ? s_cout : cout_q;
        state_d = last ? DONE : RUN;
      end
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb_multiword_add_sequencer: randomized and directed checks against a {cout,sum} arithmetic model
module tb_multiword_add_sequencer;
  localparam int W = 64;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, cin = 0, op_sub = 0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic in_ready, out_valid, cout, busy;
  int checks = 0, failures = 0;

  multiword_add_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef MWADD_SUB_EN
    .op_sub(op_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_model(input logic [W-1:0] x, y, input logic c, s);
    logic [W:0] d;
    if (!s) return {1'b0, x} + {1'b0, y} + (W+1)'(c);
    d = {1'b0, x} - {1'b0, y} - (W+1)'(c);
    return {~d[W], d[W-1:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, y, input logic c, s);
    int n = 0;
    a = x; b = y; cin = c; op_sub = s; in_valid = 1;
    while (!in_ready && n < 50) begin tick; n++; end
    tick;
    in_valid = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 50) begin tick; n++; end
  endtask

  task automatic check_result(input string name, input logic [W:0] exp);
    checks++;
    if ({cout, sum} !== exp) begin
      failures++;
      $display("FAIL %s: got cout=%0b sum=%h, expected cout=%0b sum=%h", name, cout, sum, exp[W], exp[W-1:0]);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic release_result;
    out_ready = 1; tick; out_ready = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; #12; rst_n = 1; tick;
    check_bit("reset in_ready", in_ready, 1);
    check_bit("reset out_valid", out_valid, 0);
    check_bit("reset busy", busy, 0);
    check_result("reset sum/cout", '0);
  endtask

  task automatic test_carry_chain;
    int n;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0);
    check_bit("busy after accept", busy, 1);
    wait_done(n);
    checks++;
    if (n !== 4) begin failures++; $display("FAIL latency: got %0d expected 4", n); end
    check_result("all-ones + 1", {1'b1, 64'd0});
    release_result;
    check_bit("out_valid after handshake", out_valid, 0);
    send(64'h0000_FFFF_0000_FFFF, 64'd1, 1, 0);
    wait_done(n);
    check_result("slice boundary carry", {1'b0, 64'h0000_FFFF_0001_0001});
    release_result;
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] x = {$urandom, $urandom}, y = {$urandom, $urandom};
      logic c = 1'($urandom);
      send(x, y, c, 0);
      wait_done(n);
      check_result("random add", ref_model(x, y, c, 0));
      release_result;
    end
  endtask

  task automatic test_reset_mid_run;
    int seen = 0, n;
    logic [W-1:0] x = {$urandom, $urandom}, y = {$urandom, $urandom};
    send(x, y, 0, 0);
    tick; tick;
    rst_n = 0; #1;
    check_bit("abort out_valid", out_valid, 0);
    check_bit("abort busy", busy, 0);
    check_bit("abort in_ready", in_ready, 1);
    check_result("abort sum/cout", '0);
    #3; rst_n = 1;
    for (int i = 0; i < 10; i++) begin tick; if (out_valid) seen++; end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL aborted out_valid: got %0d cycles expected 0", seen); end
    send(x, y, 1, 0);
    wait_done(n);
    check_result("post-abort request", ref_model(x, y, 1, 0));
    release_result;
  endtask

  task automatic test_backpressure;
    int n;
    logic [W-1:0] x = {$urandom, $urandom}, y = {$urandom, $urandom};
    logic [W-1:0] x2 = {$urandom, $urandom}, y2 = {$urandom, $urandom};
    logic [W:0] exp = ref_model(x, y, 1, 0);
    send(x, y, 1, 0);
    wait_done(n);
    a = x2; b = y2; cin = 0; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick;
      check_result("stall hold", exp);
      check_bit("stall in_ready", in_ready, 0);
      check_bit("stall out_valid", out_valid, 1);
    end
    out_ready = 1; tick; out_ready = 0;
    check_bit("no same-cycle accept", busy, 0);
    check_bit("idle in_ready after handshake", in_ready, 1);
    tick;
    in_valid = 0;
    check_bit("accept next cycle", busy, 1);
    wait_done(n);
    check_result("request after stall", ref_model(x2, y2, 0, 0));
    release_result;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] xs[3], ys[3];
    logic cs[3];
    int t[3];
    int na = 0, nr = 0, cyc = 0;
    for (int i = 0; i < 3; i++) begin
      xs[i] = {$urandom, $urandom}; ys[i] = {$urandom, $urandom}; cs[i] = 1'($urandom);
    end
    a = xs[0]; b = ys[0]; cin = cs[0]; op_sub = 0; in_valid = 1; out_ready = 1;
    while (nr < 3 && cyc < 100) begin
      logic acc = in_valid && in_ready;
      if (out_valid) begin
        check_result("back-to-back result", ref_model(xs[nr], ys[nr], cs[nr], 0));
        nr++;
      end
      tick; cyc++;
      if (acc) begin
        t[na] = cyc; na++;
        if (na < 3) begin a = xs[na]; b = ys[na]; cin = cs[na]; end else in_valid = 0;
      end
    end
    in_valid = 0; out_ready = 0;
    checks++;
    if (nr !== 3 || na !== 3) begin failures++; $display("FAIL back-to-back count: got %0d results %0d accepts expected 3", nr, na); end
    else for (int i = 1; i < 3; i++) begin
      checks++;
      if (t[i] - t[i-1] !== 6) begin failures++; $display("FAIL accept spacing: got %0d expected 6", t[i] - t[i-1]); end
    end
  endtask

`ifdef MWADD_SUB_EN
  task automatic test_sub;
    int n;
    send(64'd5, 64'd7, 0, 1);
    wait_done(n);
    check_result("5-7", {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    release_result;
    send(64'd7, 64'd5, 0, 1);
    wait_done(n);
    check_result("7-5", {1'b1, 64'd2});
    release_result;
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] x = {$urandom, $urandom}, y = {$urandom, $urandom};
      logic c = 1'($urandom);
      send(x, y, c, 1);
      wait_done(n);
      check_result("random sub", ref_model(x, y, c, 1));
      release_result;
    end
    op_sub = 0;
  endtask
`endif

  initial begin
    test_reset;
    test_carry_chain;
    test_reset_mid_run;
    test_backpressure;
    test_back_to_back;
`ifdef MWADD_SUB_EN
    test_sub;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
